serial_subtractor: RTL

//   Bit-serial unsigned subtractor: computes diff = din_a - din_b, LSB first, one bit per clock.
//   A single borrow flip-flop carries the borrow between bits.

---
 rtl/serial_subtractor_if.sv | 31 +++
 rtl/serial_subtractor.sv | 101 ++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Start/done operand and result bundle for the bit-serial subtractor.
// The requester (master) drives start, din_a and din_b. The subtractor (slave) drives busy, done, diff, b_out and state_dbg.
//
// Handshake rules:
//   - start is sampled only while the subtractor is not busy.
//   - din_a and din_b are captured on the same edge that accepts start.
//   - done is a one-cycle pulse.
//   - diff and b_out become valid with done and stay held until the next done.
//   - While busy, start is ignored.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] din_a;
    logic [WIDTH-1:0] din_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic [1:0]       state_dbg;

    modport master (
        output start, din_a, din_b,
        input  busy, done, diff, b_out, state_dbg
    );

    modport slave (
        input  start, din_a, din_b,
        output busy, done, diff, b_out, state_dbg
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = din_a - din_b, LSB first, one bit per clock.
// A single borrow flop links the bits; result and final borrow are held until the next done.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_res;
    logic             bor;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             b_out_q;

    logic             a0;
    logic             b0;
    logic             bit_d;
    logic             bor_nxt;
    logic [WIDTH-1:0] res_nxt;

    // One full-subtractor slice acting on the current LSBs of the shifters.
    always_comb begin
        a0      = sh_a[0];
        b0      = sh_b[0];
        bit_d   = a0 ^ b0 ^ bor;
        bor_nxt = (~a0 & b0) | (~(a0 ^ b0) & bor);
        res_nxt = {bit_d, sh_res[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            sh_a    <= '0;
            sh_b    <= '0;
            sh_res  <= '0;
            bor     <= 1'b0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        sh_a   <= bus.din_a;
                        sh_b   <= bus.din_b;
                        sh_res <= '0;
                        bor    <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    sh_res <= res_nxt;
                    bor    <= bor_nxt;
                    cnt    <= cnt + 1'b1;
                    // The last slice publishes directly from the combinational next values.
                    if (cnt == LAST_BIT) begin
                        state   <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        diff_q  <= res_nxt;
                        b_out_q <= bor_nxt;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.diff      = diff_q;
    assign bus.b_out     = b_out_q;
    assign bus.state_dbg = state;
endmodule
